sub64_seq: RTL and testbench

Multi-cycle 64-bit subtractor computing `diff = a - b - borrow_in` one 16-bit slice per clock, least-significant slice first, with a borrow register rippling between slices. It is the subtraction counterpart to the team's 16/64-bit adders and sits beside them in the arithmetic datapath. Operands are accepted and results returned over valid/ready handshakes. The block reports unsigned borrow, signed overflow and zero flags.

---
 rtl/arith_pkg.sv | 21 ++
 rtl/sub_slice16.sv | 30 +++
 rtl/sub64_seq.sv | 124 ++++++++++++
 tb/tb_sub64_seq.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic package for the sequential datapath blocks.
//
// Holds the slice geometry used by the multi-cycle adders and subtractors,
// the width of the slice index and the control state encoding.
package arith_pkg;

    // Bits processed per clock and number of slices in a 64-bit operand.
    localparam int SLICE  = 16;
    localparam int NSLICE = 64 / SLICE;

    // Width of the slice index counter.
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    // Control states of the multi-cycle blocks.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : arith_pkg

// File: rtl/sub_slice16.sv
// Combinational W-bit subtract slice with borrow-in and borrow-out.
//
// Computes diff = a - b - borrow_in as a + ~b + ~borrow_in, so the carry out
// of that addition is the inverted borrow.
//
// Ports:
//   a          in  W  minuend slice
//   b          in  W  subtrahend slice
//   borrow_in  in  1  borrow from the less-significant slice
//   diff       out W  difference slice
//   borrow_out out 1  borrow into the next slice
module sub_slice16
    import arith_pkg::*;
#(
    parameter int W = SLICE
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         borrow_in,
    output logic [W-1:0] diff,
    output logic         borrow_out
);

    logic [W:0] sum;

    assign sum        = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, ~borrow_in};
    assign diff       = sum[W-1:0];
    assign borrow_out = ~sum[W];

endmodule : sub_slice16

// File: rtl/sub64_seq.sv
// Multi-cycle subtractor: diff = a - b - borrow_in, one SLICE-bit slice per
// clock, least-significant slice first. The borrow between slices lives in a
// register, so the critical path is a single SLICE-bit add.
//
// Operands are taken over an in_valid/in_ready handshake (IDLE only), the
// result is returned over out_valid/out_ready (DONE only). Results and flags
// hold steady for as long as the consumer stalls.
//
// Ports:
//   clk        in  1      clock, rising edge
//   rst_n      in  1      asynchronous active-low reset
//   in_valid   in  1      operand request
//   in_ready   out 1      block is idle and will take operands
//   a          in  WIDTH  minuend
//   b          in  WIDTH  subtrahend
//   borrow_in  in  1      incoming borrow
//   out_valid  out 1      result available
//   out_ready  in  1      consumer accepts result
//   diff       out WIDTH  a - b - borrow_in mod 2^WIDTH
//   borrow_out out 1      unsigned borrow (a < b + borrow_in)
//   ovf        out 1      signed overflow
//   zero       out 1      diff == 0
//
// WIDTH must be a multiple of SLICE.
module sub64_seq #(
    parameter int WIDTH = 64,
    parameter int SLICE = arith_pkg::SLICE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             ovf,
    output logic             zero
);

    import arith_pkg::*;

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    state_t             state;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [WIDTH-1:0]   diff_reg;
    logic               borrow_reg;
    logic [IDX_W-1:0]   idx;

    logic [SLICE-1:0]   slice_diff;
    logic               slice_borrow;

    // One slice subtractor, fed from the latched operands by the slice index.
    sub_slice16 #(
        .W (SLICE)
    ) u_slice (
        .a          (a_reg[idx*SLICE +: SLICE]),
        .b          (b_reg[idx*SLICE +: SLICE]),
        .borrow_in  (borrow_reg),
        .diff       (slice_diff),
        .borrow_out (slice_borrow)
    );

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples the pre-edge values, regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            diff_reg   <= '0;
            borrow_reg <= 1'b0;
            idx        <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg      <= a;
                        b_reg      <= b;
                        borrow_reg <= borrow_in;
                        idx        <= '0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    diff_reg[idx*SLICE +: SLICE] <= slice_diff;
                    borrow_reg                   <= slice_borrow;
                    if (idx == LAST_IDX) begin
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == DONE);
    assign diff       = diff_reg;
    assign borrow_out = borrow_reg;

    // Flags are qualified by DONE so they read 0 out of reset and while a
    // partial result is being assembled. The operand MSBs stay latched until
    // the next accept, so they remain valid throughout DONE.
    assign ovf  = out_valid
                & (a_reg[WIDTH-1] ^ b_reg[WIDTH-1])
                & (diff_reg[WIDTH-1] ^ a_reg[WIDTH-1]);
    assign zero = out_valid & ~|diff_reg;

endmodule : sub64_seq

// File: tb/tb_sub64_seq.sv
// Self-checking bench for sub64_seq: directed vectors, randomized operands
// against a plain-arithmetic reference, backpressure, back-to-back throughput
// and asynchronous reset in the middle of a computation.
module tb_sub64_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a;
    logic [63:0] b;
    logic        borrow_in;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] diff;
    logic        borrow_out;
    logic        ovf;
    logic        zero;

    int n_checks;
    int n_pass;

    typedef struct packed {
        logic [63:0] d;
        logic        bo;
        logic        ov;
        logic        z;
    } res_t;

    sub64_seq #(
        .WIDTH (64),
        .SLICE (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .borrow_in  (borrow_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .diff       (diff),
        .borrow_out (borrow_out),
        .ovf        (ovf),
        .zero       (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: whole-word arithmetic. Borrow is the sign of the 65-bit
    // unsigned difference; overflow means the exact signed result does not
    // fit back into 64 bits.
    function automatic res_t model(input logic [63:0] x, input logic [63:0] y,
                                   input logic bin);
        res_t        r;
        logic [64:0] w;
        logic [65:0] s;
        w    = {1'b0, x} - {1'b0, y} - {64'd0, bin};
        s    = {{2{x[63]}}, x} - {{2{y[63]}}, y} - {65'd0, bin};
        r.d  = w[63:0];
        r.bo = w[64];
        r.ov = (s != {{2{w[63]}}, w[63:0]});
        r.z  = (w[63:0] == 64'd0);
        return r;
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    // Drives one full transaction: accept, wait for out_valid, handshake.
    // Reports the result, cycles from accept to out_valid, and the handshake
    // signals one cycle after the result was taken.
    task automatic run_op(input logic [63:0] x, input logic [63:0] y,
                          input logic bin, output res_t got, output int lat,
                          output logic post_valid, output logic post_ready);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        a = x; b = y; borrow_in = bin; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        a         = rand64();
        b         = rand64();
        borrow_in = $urandom_range(0, 1);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        got = '{d: diff, bo: borrow_out, ov: ovf, z: zero};
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready  = 1'b0;
        post_valid = out_valid;
        post_ready = in_ready;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b1; a = 64'h5; b = 64'h3; borrow_in = 1'b1; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b want=1", in_ready); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b want=0", out_valid); else n_pass++;
        n_checks++; if (diff !== 64'd0) $display("FAIL reset_diff got=%h want=0", diff); else n_pass++;
        n_checks++; if ({borrow_out, ovf, zero} !== 3'b000) $display("FAIL reset_flags got=%b want=000", {borrow_out, ovf, zero}); else n_pass++;
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_idle_after got=%b want=1", in_ready); else n_pass++;
    endtask

    task automatic test_directed();
        logic [63:0] va [5];
        logic [63:0] vb [5];
        logic        vi [5];
        res_t        want [5];
        res_t        got;
        int          lat;
        logic        pv, pr;
        va[0] = 64'h5;                   vb[0] = 64'h3;                   vi[0] = 1'b0;
        want[0] = '{d: 64'h2, bo: 1'b0, ov: 1'b0, z: 1'b0};
        va[1] = 64'h0;                   vb[1] = 64'h1;                   vi[1] = 1'b0;
        want[1] = '{d: 64'hFFFF_FFFF_FFFF_FFFF, bo: 1'b1, ov: 1'b0, z: 1'b0};
        va[2] = 64'h8000_0000_0000_0000; vb[2] = 64'h1;                   vi[2] = 1'b0;
        want[2] = '{d: 64'h7FFF_FFFF_FFFF_FFFF, bo: 1'b0, ov: 1'b1, z: 1'b0};
        va[3] = 64'h1234_5678_9ABC_DEF0; vb[3] = 64'h1234_5678_9ABC_DEF0; vi[3] = 1'b0;
        want[3] = '{d: 64'h0, bo: 1'b0, ov: 1'b0, z: 1'b1};
        va[4] = 64'h1234_5678_9ABC_DEF0; vb[4] = 64'h1234_5678_9ABC_DEF0; vi[4] = 1'b1;
        want[4] = '{d: 64'hFFFF_FFFF_FFFF_FFFF, bo: 1'b1, ov: 1'b0, z: 1'b0};
        for (int i = 0; i < 5; i++) begin
            run_op(va[i], vb[i], vi[i], got, lat, pv, pr);
            n_checks++; if (lat !== 4) $display("FAIL dir%0d_latency got=%0d want=4", i, lat); else n_pass++;
            n_checks++; if (got !== want[i]) $display("FAIL dir%0d_result got=%h/%b%b%b want=%h/%b%b%b", i,
                got.d, got.bo, got.ov, got.z, want[i].d, want[i].bo, want[i].ov, want[i].z); else n_pass++;
            n_checks++; if ({pv, pr} !== 2'b01) $display("FAIL dir%0d_release got=%b want=01", i, {pv, pr}); else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [63:0] x, y;
        logic        bin;
        res_t        want, got;
        int          lat;
        logic        pv, pr;
        for (int i = 0; i < 60; i++) begin
            x = rand64(); y = rand64(); bin = $urandom_range(0, 1);
            case ($urandom_range(0, 3))
                0: y = x;
                1: begin x[63] = 1'b1; y[63] = 1'b0; end
                2: begin x[63] = 1'b0; y[63] = 1'b1; end
                default: ;
            endcase
            want = model(x, y, bin);
            run_op(x, y, bin, got, lat, pv, pr);
            n_checks++; if (lat !== 4) $display("FAIL rnd%0d_latency got=%0d want=4", i, lat); else n_pass++;
            n_checks++; if (got !== want) $display("FAIL rnd%0d a=%h b=%h bin=%b got=%h/%b%b%b want=%h/%b%b%b", i, x, y, bin,
                got.d, got.bo, got.ov, got.z, want.d, want.bo, want.ov, want.z); else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] x1, y1, x2, y2;
        res_t        want1, want2, held, now;
        int          lat;
        x1 = rand64(); y1 = rand64(); x2 = rand64(); y2 = rand64();
        want1 = model(x1, y1, 1'b1);
        want2 = model(x2, y2, 1'b0);
        a = x1; b = y1; borrow_in = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        a = x2; b = y2; borrow_in = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        held = '{d: diff, bo: borrow_out, ov: ovf, z: zero};
        n_checks++; if (held !== want1) $display("FAIL bp_result got=%h want=%h", held.d, want1.d); else n_pass++;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            now = '{d: diff, bo: borrow_out, ov: ovf, z: zero};
            n_checks++; if (now !== held) $display("FAIL bp_hold%0d got=%h/%b%b%b want=%h/%b%b%b", i,
                now.d, now.bo, now.ov, now.z, held.d, held.bo, held.ov, held.z); else n_pass++;
            n_checks++; if ({out_valid, in_ready} !== 2'b10) $display("FAIL bp_hs%0d got=%b want=10", i, {out_valid, in_ready}); else n_pass++;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_checks++; if ({out_valid, in_ready} !== 2'b01) $display("FAIL bp_idle got=%b want=01", {out_valid, in_ready}); else n_pass++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_new_accept got=%b want=0", in_ready); else n_pass++;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        now = '{d: diff, bo: borrow_out, ov: ovf, z: zero};
        n_checks++; if (lat !== 4) $display("FAIL bp_new_latency got=%0d want=4", lat); else n_pass++;
        n_checks++; if (now !== want2) $display("FAIL bp_new_result got=%h want=%h", now.d, want2.d); else n_pass++;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [63:0] x1, y1, x2, y2;
        res_t        want1, want2, got;
        int          t, seen, seen_t, lat;
        x1 = rand64(); y1 = rand64(); x2 = rand64(); y2 = rand64();
        want1 = model(x1, y1, 1'b0);
        want2 = model(x2, y2, 1'b1);
        out_ready = 1'b1;
        a = x1; b = y1; borrow_in = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        a = x2; b = y2; borrow_in = 1'b1;
        t = 0; seen = 0; seen_t = -1;
        while (!in_ready && t < 20) begin
            @(posedge clk); #1;
            t++;
            if (out_valid) begin
                seen++;
                seen_t = t;
                got = '{d: diff, bo: borrow_out, ov: ovf, z: zero};
            end
        end
        n_checks++; if (seen !== 1 || seen_t !== 4) $display("FAIL b2b_valid_window got=%0d@%0d want=1@4", seen, seen_t); else n_pass++;
        n_checks++; if (got !== want1) $display("FAIL b2b_first got=%h want=%h", got.d, want1.d); else n_pass++;
        n_checks++; if (t + 1 !== 6) $display("FAIL b2b_interval got=%0d want=6", t + 1); else n_pass++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL b2b_second_accept got=%b want=0", in_ready); else n_pass++;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        got = '{d: diff, bo: borrow_out, ov: ovf, z: zero};
        n_checks++; if (lat !== 4) $display("FAIL b2b_second_latency got=%0d want=4", lat); else n_pass++;
        n_checks++; if (got !== want2) $display("FAIL b2b_second got=%h want=%h", got.d, want2.d); else n_pass++;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        res_t got;
        int   lat;
        logic pv, pr;
        a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'h1; borrow_in = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        n_checks++; if (diff === 64'd0) $display("FAIL mid_partial got=%h want=nonzero", diff); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL mid_out_valid got=%b want=0", out_valid); else n_pass++;
        n_checks++; if (diff !== 64'd0) $display("FAIL mid_diff got=%h want=0", diff); else n_pass++;
        n_checks++; if ({in_ready, borrow_out, ovf, zero} !== 4'b1000) $display("FAIL mid_ctrl got=%b want=1000",
            {in_ready, borrow_out, ovf, zero}); else n_pass++;
        #2;
        rst_n = 1'b1;
        run_op(64'h10, 64'h1, 1'b0, got, lat, pv, pr);
        n_checks++; if (lat !== 4) $display("FAIL mid_after_latency got=%0d want=4", lat); else n_pass++;
        n_checks++; if (got !== '{d: 64'hF, bo: 1'b0, ov: 1'b0, z: 1'b0}) $display("FAIL mid_after_result got=%h/%b%b%b want=f/000",
            got.d, got.bo, got.ov, got.z); else n_pass++;
    endtask

    initial begin
        #400us;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; borrow_in = 1'b0; rst_n = 1'b1;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_sub64_seq
